// File: rtl/mcpu_console_pkg.sv
// mcpu_console_pkg: state encoding, control codes and screen geometry for the text console.
package mcpu_console_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PUT, S_CLR, S_SCR_RD, S_SCR_WR, S_SCR_CLR} state_t;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam int COLS = 32;
    localparam int ROWS = 32;
    localparam int SCROLL_WORDS = 992;
    function automatic logic is_ctrl(input logic [7:0] c);
        return c == CC_BS || c == CC_LF || c == CC_FF || c == CC_CR;
    endfunction
endpackage

// File: rtl/mcpu_console_cursor.sv
// mcpu_console_cursor: cursor row/column register with advance, line feed, CR, BS, home and bottom moves.
module mcpu_console_cursor
    import mcpu_console_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       lf,
    input  logic       cr,
    input  logic       bs,
    input  logic       home,
    input  logic       bottom,
    output logic [4:0] row,
    output logic [4:0] col
);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    // advance and lf may coincide (auto-wrap); 5-bit arithmetic wraps naturally
    always_ff @(posedge clk) begin
        if (reset || home) begin
            row <= '0;
            col <= '0;
        end else if (bottom) begin
            row <= LAST_ROW;
            col <= '0;
        end else if (bs) begin
            if (col != '0) col <= col - 5'd1;
            else if (row != '0) begin
                row <= row - 5'd1;
                col <= LAST_COL;
            end
        end else if (cr) begin
            col <= '0;
        end else begin
            if (advance) col <= col + 5'd1;
            if (lf) row <= row + 5'd1;
        end
    end
endmodule

// File: rtl/mcpu_console.sv
// mcpu_console: byte-stream text console writing a 32x32 VRAM page, with clear and scroll engines.
module mcpu_console
    import mcpu_console_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter bit         SCROLL_EN = 1'b1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic [2:0]  page,
    output logic [12:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic [4:0]  cur_row,
    output logic [4:0]  cur_col,
    output logic        busy
);
    localparam logic [9:0] COPY_LAST = 10'(SCROLL_WORDS - 1);
    localparam logic [9:0] FILL_BASE = 10'(SCROLL_WORDS);
    localparam logic [9:0] ROW_WORDS = 10'(COLS);
    state_t      r_state;
    logic [9:0]  r_cnt;
    logic [2:0]  r_page;
    logic        r_we;
    logic [12:0] r_addr;
    logic [7:0]  r_wdata;
    logic w_accept, w_at_bottom, w_end_of_row, w_lf_scroll, w_put_scroll, w_lf;
    assign w_accept     = r_state == S_IDLE && char_valid;
    assign w_at_bottom  = SCROLL_EN && cur_row == 5'(ROWS - 1);
    assign w_end_of_row = cur_col == 5'(COLS - 1);
    assign w_lf_scroll  = w_accept && char_data == CC_LF && w_at_bottom;
    assign w_put_scroll = r_state == S_PUT && w_end_of_row && w_at_bottom;
    // at the bottom with scrolling enabled the scroll engine repositions the cursor instead
    assign w_lf = ((w_accept && char_data == CC_LF) || (r_state == S_PUT && w_end_of_row)) && !w_at_bottom;
    mcpu_console_cursor u_cursor (
        .clk     (clk),
        .reset   (reset),
        .advance (r_state == S_PUT),
        .lf      (w_lf),
        .cr      (w_accept && char_data == CC_CR),
        .bs      (w_accept && char_data == CC_BS),
        .home    (r_state == S_CLR && r_cnt == 10'h3FF),
        .bottom  (r_state == S_SCR_CLR && r_cnt == 10'd31),
        .row     (cur_row),
        .col     (cur_col)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_page  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (char_valid) begin
                    r_page <= page;
                    if (char_data == CC_FF) begin
                        r_state <= S_CLR;
                        r_cnt   <= '0;
                        r_we    <= 1'b1;
                        r_addr  <= {page, 10'd0};
                        r_wdata <= FILL_CHAR;
                    end else if (w_lf_scroll) begin
                        r_state <= S_SCR_RD;
                        r_cnt   <= '0;
                        r_addr  <= {page, ROW_WORDS};
                    end else if (!is_ctrl(char_data)) begin
                        r_state <= S_PUT;
                        r_we    <= 1'b1;
                        r_addr  <= {page, cur_row, cur_col};
                        r_wdata <= char_data;
                    end
                end
                S_PUT: begin
                    r_we <= 1'b0;
                    if (w_put_scroll) begin
                        r_state <= S_SCR_RD;
                        r_cnt   <= '0;
                        r_addr  <= {r_page, ROW_WORDS};
                    end else r_state <= S_IDLE;
                end
                S_CLR, S_SCR_CLR: begin
                    if (r_cnt == (r_state == S_CLR ? 10'h3FF : 10'd31)) begin
                        r_state <= S_IDLE;
                        r_we    <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + 10'd1;
                        r_addr <= {r_page, r_addr[9:0] + 10'd1};
                    end
                end
                S_SCR_RD: begin
                    r_state <= S_SCR_WR;
                    r_we    <= 1'b1;
                    r_addr  <= {r_page, r_cnt};
                    r_wdata <= vram_rdata;
                end
                S_SCR_WR: begin
                    if (r_cnt == COPY_LAST) begin
                        r_state <= S_SCR_CLR;
                        r_cnt   <= '0;
                        r_addr  <= {r_page, FILL_BASE};
                        r_wdata <= FILL_CHAR;
                    end else begin
                        r_state <= S_SCR_RD;
                        r_we    <= 1'b0;
                        r_cnt   <= r_cnt + 10'd1;
                        r_addr  <= {r_page, r_cnt + ROW_WORDS + 10'd1};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign char_ready = r_state == S_IDLE;
    assign busy       = r_state != S_IDLE;
    assign vram_we    = r_we;
    assign vram_addr  = r_addr;
    assign vram_wdata = r_wdata;
endmodule

// File: tb/tb_mcpu_console.sv
// tb_mcpu_console: directed stimulus against a screen-level model with a per-write scoreboard.
module tb_mcpu_console;
    logic        clk = 1'b0;
    logic        reset, char_valid, char_ready, vram_we, busy;
    logic [7:0]  char_data, vram_wdata, vram_rdata;
    logic [2:0]  page;
    logic [12:0] vram_addr;
    logic [4:0]  cur_row, cur_col;
    logic [7:0]  vram [8192];
    logic [7:0]  mdl [8192];
    logic [7:0]  ref_mem [8192];
    logic [20:0] exp_q [$];
    int errors = 0, checks = 0, nwr = 0, m_row = 0, m_col = 0;
    logic [12:0] last_waddr;
    logic [7:0]  last_wdata;

    mcpu_console dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .page(page), .vram_addr(vram_addr), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .cur_row(cur_row),
        .cur_col(cur_col), .busy(busy)
    );

    always #5 clk = ~clk;
    assign vram_rdata = vram[vram_addr];
    always @(posedge clk) if (vram_we) vram[vram_addr] <= vram_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // every write the DUT issues must be the next one the model predicted
    always @(negedge clk) begin
        if (vram_we) begin
            nwr++;
            last_waddr = vram_addr;
            last_wdata = vram_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h:%h required=none", vram_addr, vram_wdata);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                chk("vram_write", {vram_addr, vram_wdata}, e);
                ref_mem[e[20:8]] = e[7:0];
            end
        end
    end

    task automatic mdl_push(input int a, input logic [7:0] d);
        exp_q.push_back({13'(a), d});
        mdl[a] = d;
    endtask

    task automatic mdl_lf(input int p, inout int eb);
        if (m_row < 31) m_row++;
        else begin
            for (int i = 0; i < 992; i++) mdl_push(p * 1024 + i, mdl[p * 1024 + i + 32]);
            for (int i = 992; i < 1024; i++) mdl_push(p * 1024 + i, 8'h20);
            m_col = 0;
            eb += 2016;
        end
    endtask

    task automatic mdl_char(input logic [7:0] c, input int p, output int eb);
        eb = 0;
        if (c == 8'h0C) begin
            for (int a = 0; a < 1024; a++) mdl_push(p * 1024 + a, 8'h20);
            m_row = 0;
            m_col = 0;
            eb = 1024;
        end else if (c == 8'h0D) m_col = 0;
        else if (c == 8'h08) begin
            if (m_col > 0) m_col--;
            else if (m_row > 0) begin
                m_row--;
                m_col = 31;
            end
        end else if (c == 8'h0A) mdl_lf(p, eb);
        else begin
            mdl_push(p * 1024 + m_row * 32 + m_col, c);
            eb = 1;
            m_col++;
            if (m_col == 32) begin
                m_col = 0;
                mdl_lf(p, eb);
            end
        end
    endtask

    // called just after a negedge with the DUT idle; returns the observed busy length
    task automatic send(input logic [7:0] c, input logic [2:0] p, output int n);
        int eb, bad;
        mdl_char(c, int'(p), eb);
        bad = char_ready ? 0 : 1;
        char_valid = 1'b1;
        char_data  = c;
        page       = p;
        @(negedge clk);
        char_valid = 1'b0;
        page       = ~p;
        n = 0;
        while (busy && n < 3000) begin
            if (char_ready) bad++;
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, eb);
        chk("ready_while_busy", bad, 0);
        chk("cursor", {cur_row, cur_col}, {5'(m_row), 5'(m_col)});
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0, seen, mm;
        for (int a = 0; a < 8192; a++) begin
            vram[a] = 8'h00;
            mdl[a] = 8'h00;
            ref_mem[a] = 8'h00;
        end
        reset = 1'b1;
        char_valid = 1'b0;
        char_data = 8'h00;
        page = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cursor", {cur_row, cur_col}, 10'd0);
        chk("rst_we", vram_we, 0);
        chk("rst_addr", vram_addr, 0);
        chk("rst_wdata", vram_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", char_ready, 1);

        send(8'h48, 3'd1, n);
        chk("h_addr", last_waddr, 13'h0400);
        chk("h_data", last_wdata, 8'h48);
        chk("h_cursor", {cur_row, cur_col}, {5'd0, 5'd1});
        chk("h_busy", n, 1);

        send(8'h0D, 3'd0, n);
        for (int i = 0; i < 32; i++) send(8'h41, 3'd0, n);
        chk("a_last_addr", last_waddr, 13'h001F);
        chk("a_cursor", {cur_row, cur_col}, {5'd1, 5'd0});

        for (int i = 0; i < 30; i++) send(8'h0A, 3'd0, n);
        for (int i = 0; i < 5; i++) send(8'h78, 3'd0, n);
        chk("pre_scroll_cursor", {cur_row, cur_col}, {5'd31, 5'd5});
        for (int a = 0; a < 1024; a++) begin
            vram[a] = 8'(a / 32);
            mdl[a] = 8'(a / 32);
            ref_mem[a] = 8'(a / 32);
        end
        send(8'h0A, 3'd0, n);
        chk("scroll_busy", n, 2016);
        chk("scroll_vram0", vram[0], 1);
        chk("scroll_vram960", vram[960], 31);
        chk("scroll_vram992", vram[992], 8'h20);
        chk("scroll_vram1023", vram[1023], 8'h20);
        chk("scroll_cursor", {cur_row, cur_col}, {5'd31, 5'd0});

        n0 = nwr;
        send(8'h0C, 3'd2, n);
        chk("clr_writes", nwr - n0, 1024);
        chk("clr_last_addr", last_waddr, 13'h0BFF);
        chk("clr_vram_first", vram[13'h0800], 8'h20);
        chk("clr_cursor", {cur_row, cur_col}, 10'd0);

        n0 = nwr;
        send(8'h08, 3'd2, n);
        send(8'h0D, 3'd2, n);
        chk("ctl_no_writes", nwr - n0, 0);
        chk("ctl_cursor", {cur_row, cur_col}, 10'd0);
        for (int i = 0; i < 3; i++) send(8'h0A, 3'd2, n);
        send(8'h08, 3'd2, n);
        chk("bs_wrap_cursor", {cur_row, cur_col}, {5'd2, 5'd31});

        // abort a clear of page 3 in its 500th cycle
        mdl_char(8'h0C, 3, n);
        n0 = nwr;
        char_valid = 1'b1;
        char_data = 8'h0C;
        page = 3'd3;
        @(negedge clk);
        char_valid = 1'b0;
        repeat (499) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        for (int a = 0; a < 8192; a++) mdl[a] = ref_mem[a];
        chk("abort_writes", nwr - n0, 500);
        seen = 0;
        repeat (4) begin
            if (vram_we) seen++;
            @(negedge clk);
        end
        chk("abort_no_write", seen, 0);
        chk("abort_cursor", {cur_row, cur_col}, 10'd0);
        chk("abort_ready", char_ready, 1);
        send(8'h5A, 3'd3, n);
        chk("post_abort_addr", last_waddr, 13'h0C00);
        chk("post_abort_data", last_wdata, 8'h5A);

        mm = 0;
        for (int a = 0; a < 8192; a++) if (vram[a] !== ref_mem[a]) mm++;
        chk("vram_image", mm, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
